// File: rtl/if_fetch_buf.sv
// Fetch buffer between the PC stage and IF/ID: queues 64-bit bundles, issues 32-bit words.
// Optional same-cycle bypass of an incoming bundle into an empty buffer: define FETCH_BUF_BYPASS_EN.
module if_fetch_buf #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce_i,
   input  logic [31:0] pc_i,
   input  logic [63:0] inst_i,
   input  logic        flush_i,
   input  logic        id_ready_i,
   output logic        id_valid_o,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_inst_o,
   output logic        stall_req_o,
   output logic        full_o,
   output logic        overflow_o
);

   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [28:0]   r_mem_pc   [DEPTH];
   logic [63:0]   r_mem_inst [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [AW:0]   r_count;
   logic          r_h;
   logic          r_stall;
   logic          r_ovf;

   logic          w_empty;
   logic          w_full;
   logic          w_fire;
   logic          w_pop;
   logic          w_write;
   logic          w_drop;
   logic [AW:0]   w_next_count;
   logic [28:0]   w_rd_pc;
   logic [63:0]   w_rd_inst;
   logic          w_unused;

   // Handshake: a word transfers on any edge where id_valid_o && id_ready_i;
   // while id_valid_o=1 and id_ready_i=0 the presented word is held unchanged.
   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == DEPTH_C);
   assign w_fire    = id_valid_o & id_ready_i;
   assign w_pop     = w_fire & r_h;
   assign w_write   = ce_i & ~flush_i & (~w_full | w_pop);
   assign w_drop    = ce_i & ~flush_i & w_full & ~w_pop;
   assign w_rd_pc   = r_mem_pc[r_rp];
   assign w_rd_inst = r_mem_inst[r_rp];
   assign w_unused  = ^pc_i[2:0];

   always_comb begin
      w_next_count = r_count;
      if (w_write && !w_pop)
         w_next_count = r_count + CNT_ONE;
      else if (!w_write && w_pop)
         w_next_count = r_count - CNT_ONE;
   end

   always_comb begin
      id_valid_o = 1'b0;
      id_pc_o    = '0;
      id_inst_o  = '0;
      if (!w_empty) begin
         id_valid_o = 1'b1;
         id_pc_o    = {w_rd_pc, r_h, 2'b00};
         id_inst_o  = r_h ? w_rd_inst[31:0] : w_rd_inst[63:32];
      end
`ifdef FETCH_BUF_BYPASS_EN
      else if (ce_i && !flush_i && !rst) begin
         id_valid_o = 1'b1;
         id_pc_o    = {pc_i[31:3], 3'b000};
         id_inst_o  = inst_i[63:32];
      end
`endif
   end

   assign full_o      = w_full;
   assign stall_req_o = r_stall;
   assign overflow_o  = r_ovf;

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (!rst && w_write) begin
         r_mem_pc[r_wp]   <= pc_i[31:3];
         r_mem_inst[r_wp] <= inst_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
         r_h     <= 1'b0;
         r_stall <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_write)
            r_wp <= r_wp + PTR_ONE;
         if (w_pop)
            r_rp <= r_rp + PTR_ONE;
         if (w_fire)
            r_h <= ~r_h;
         if (w_drop)
            r_ovf <= 1'b1;
         r_count <= w_next_count;
         // One entry of slack covers the bundle already launched by the PC stage.
         r_stall <= (w_next_count >= (DEPTH_C - CNT_ONE));
      end
   end

endmodule
